// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Two-state handshake sequencer: idle and granting, or waiting on memory.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    // Which stage owns the transaction currently in flight.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    // Everything captured at grant time and replayed to memory during WAIT.
    typedef struct packed {
        arb_owner_e          owner;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } arb_txn_t;

    // Memory is word addressed; the low byte-offset bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and MEM-stage (D) ports onto one single-ported
// memory. One transaction in flight; D wins ties unless I has been starved
// for STARVE_LIMIT consecutive D grants. A memory that never acknowledges
// is abandoned after TIMEOUT cycles and reported through bus_err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              bus_err
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    arb_state_e          state;
    arb_txn_t            txn;
    arb_txn_t            grant_txn;
    logic [STREAK_W-1:0] streak;
    logic [TMO_W-1:0]    tmo;
    logic                grant_i;
    logic                grant_d;
    logic                grant_misaligned;

    // Consecutive-D-grant counter: grows only while fetch is left waiting,
    // saturates at the limit, and clears on any grant that does not starve I.
    function automatic logic [STREAK_W-1:0] streak_next(
        input logic [STREAK_W-1:0] s,
        input logic                d_won,
        input logic                i_waiting
    );
        if (d_won && i_waiting) begin
            return (s == STREAK_MAX) ? s : s + 1'b1;
        end
        return '0;
    endfunction

    // Loads return memory data; stores complete with zero.
    function automatic logic [DATA_W-1:0] result_data(
        input logic              we,
        input logic [DATA_W-1:0] rd
    );
        return we ? '0 : rd;
    endfunction

    // Grant decision: only from IDLE, D preferred unless I has hit the starvation limit.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst && state == ST_IDLE) begin
            if (if_req && (!d_req || streak == STREAK_MAX)) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // Transaction captured from the winning port; fetch is always a read.
    always_comb begin
        grant_txn        = txn;
        grant_misaligned = 1'b0;
        if (grant_d) begin
            grant_txn        = '{owner: OWN_D, we: d_we, addr: word_align(d_addr), wdata: d_wdata};
            grant_misaligned = is_misaligned(d_addr);
        end else if (grant_i) begin
            grant_txn        = '{owner: OWN_I, we: 1'b0, addr: word_align(if_addr), wdata: '0};
            grant_misaligned = is_misaligned(if_addr);
        end
    end

    assign if_gnt    = grant_i;
    assign d_gnt     = grant_d;
    assign busy      = (state != ST_IDLE);
    assign mem_req   = (state == ST_WAIT);
    assign mem_we    = mem_req & txn.we;
    assign mem_addr  = mem_req ? txn.addr  : '0;
    assign mem_wdata = mem_req ? txn.wdata : '0;

    // Handshake FSM with registered result pulses and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            txn      <= '0;
            streak   <= '0;
            tmo      <= '0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            bus_err  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        txn    <= grant_txn;
                        tmo    <= '0;
                        streak <= streak_next(streak, grant_d, if_req);
                        state  <= ST_WAIT;
                        if (grant_misaligned) begin
                            bus_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        if (txn.owner == OWN_I) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_valid <= 1'b1;
                            d_rdata <= result_data(txn.we, mem_rdata);
                        end
                        state <= ST_IDLE;
                    end else if (tmo == TMO_LAST) begin
                        // Abandon the access: complete to the owner with zero data.
                        if (txn.owner == OWN_I) begin
                            if_valid <= 1'b1;
                            if_rdata <= '0;
                        end else begin
                            d_valid <= 1'b1;
                            d_rdata <= '0;
                        end
                        bus_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single/dual-port transactions plus
// hand sequences for starvation, timeout, misalignment and reset-in-WAIT.
// A scoreboard queue is filled at each grant and drained at each valid.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        bus_err;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural backing memory.
    logic [31:0] bmem [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return 32'h0BAD_0000 | {16'h0, a[15:0]};
    endfunction

    // Memory responder: ack_delay = WAIT cycles before ack (0 = first), -1 = never.
    int   ack_delay = 0;
    int   req_cnt   = 0;
    logic stray_ack = 1'b0;

    always @(negedge clk) begin
        if (mem_req && !rst) begin
            if (ack_delay >= 0 && req_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 32'hFFFF_FFFF : mem_read(mem_addr);
                if (mem_we) bmem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
            req_cnt++;
        end else begin
            mem_ack   = stray_ack;
            mem_rdata = 32'h1357_9BDF;
            req_cnt   = 0;
        end
    end

    // Scoreboard.
    typedef struct {
        logic        port_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          vcyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mq[$];
    logic        mem_req_q = 1'b0;
    logic [31:0] last_if_rdata;
    logic [31:0] last_d_rdata;
    int          last_d_valid_cyc;
    int          last_i_gnt_cyc;

    always @(negedge clk) begin
        exp_t e;
        exp_t m;
        if (rst) begin
            exp_q.delete();
            mq.delete();
        end else begin
            if (if_gnt && d_gnt) chk("gnt_exclusive", 32'd1, 32'd0);
            if (if_gnt || d_gnt) begin
                e.port_d = d_gnt;
                e.we     = d_gnt ? d_we : 1'b0;
                e.addr   = d_gnt ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
                e.wdata  = d_gnt ? d_wdata : 32'h0;
                if (ack_delay < 0)  e.rdata = 32'h0;
                else if (e.we)      e.rdata = 32'h0;
                else                e.rdata = mem_read(e.addr);
                e.vcyc   = cyc + ((ack_delay < 0) ? (1 + TIMEOUT) : (2 + ack_delay));
                exp_q.push_back(e);
                mq.push_back(e);
                if (if_gnt) last_i_gnt_cyc = cyc;
            end
            if (if_valid || d_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {30'h0, d_valid, if_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_port_d", d_valid, e.port_d);
                    chk("valid_rdata", d_valid ? d_rdata : if_rdata, e.rdata);
                    chk("valid_cycle", cyc, e.vcyc);
                end
                if (if_valid) last_if_rdata = if_rdata;
                if (d_valid) begin
                    last_d_rdata     = d_rdata;
                    last_d_valid_cyc = cyc;
                end
            end
            if (mem_req && !mem_req_q) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    m = mq.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", mem_we, m.we);
                    chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
        end
        mem_req_q = mem_req;
    end

    // Table of transactions.
    typedef struct {
        logic        i_en;
        logic [31:0] i_addr;
        logic        d_en;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          ack_dly;
        logic        exp_first_d;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; stray_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk({name, "_drain_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int   t;
        logic gi, gd, seen, first_d;
        gi = 1'b0; gd = 1'b0; seen = 1'b0; first_d = 1'b0;
        last_if_rdata = 32'hEEEE_EEEE;
        last_d_rdata  = 32'hEEEE_EEEE;
        @(posedge clk); #1;
        ack_delay = v.ack_dly;
        if_req = v.i_en; if_addr = v.i_addr;
        d_req = v.d_en; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        t = 0;
        while ((if_req || d_req || busy || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            if (!seen && (if_gnt || d_gnt)) begin
                seen = 1'b1;
                first_d = d_gnt;
            end
            if (if_gnt) gi = 1'b1;
            if (d_gnt)  gd = 1'b1;
            @(posedge clk); #1;
            if (gi) if_req = 1'b0;
            if (gd) d_req = 1'b0;
            t++;
        end
        if (t >= 200) chk({name, "_timeout"}, 32'd1, 32'd0);
        chk({name, "_first_d"}, first_d, v.exp_first_d);
        if (v.i_en) chk({name, "_if_rdata"}, last_if_rdata, v.exp_i);
        if (v.d_en) chk({name, "_d_rdata"}, last_d_rdata, v.exp_d);
        if (v.i_en && v.d_en) chk({name, "_i_gnt_at_d_valid"}, last_i_gnt_cyc, last_d_valid_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, k, hi;
        logic        seen;
        logic [9:0]  pat;
        vec_t        mis;

        bmem[32'h40]  = 32'h8C22_0004;
        bmem[32'h80]  = 32'hDEAD_BEEF;
        bmem[32'h100] = 32'h0000_1111;
        bmem[32'h10]  = 32'h0000_0000;

        //           i_en addr      d_en we addr       wdata          dly first  exp_i          exp_d
        vecs[0] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,         0, 1'b0, 32'h8C22_0004, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h80,  32'h0,         1, 1'b1, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  32'h1234,      0, 1'b1, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  32'h0,         2, 1'b1, 32'h0,         32'h1234};
        vecs[4] = '{1'b1, 32'h40,  1'b1, 1'b0, 32'h100, 32'h0,         0, 1'b1, 32'h8C22_0004, 32'h0000_1111};
        vecs[5] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h80,  32'hCAFE_F00D, 1, 1'b1, 32'h0000_1111, 32'h0};
        vecs[6] = '{1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,         3, 1'b0, 32'hCAFE_F00D, 32'h0};

        // Reset state, with both requests asserted during reset.
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valids", {if_valid, d_valid}, 2'b00);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_bus_err", bus_err, 1'b0);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; rst = 1'b0;

        // Table-driven transactions.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        chk("table_bus_err", bus_err, 1'b0);

        // Starvation: both held, grants D D D D I D D D D I.
        pat = 10'b0111101111;
        ack_delay = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        k = 0; t = 0;
        while (k < 10 && t < 300) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                chk($sformatf("starve_grant%0d_d", k), d_gnt, pat[k]);
                k++;
            end
            t++;
        end
        if (k < 10) chk("starve_grant_count", k, 10);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        drain("starve");

        // Timeout: no ack, mem_req held TIMEOUT cycles, zero data, sticky error.
        ack_delay = -1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        t = 0;
        do begin @(negedge clk); t++; end while (!if_gnt && t < 20);
        @(posedge clk); #1;
        if_req = 1'b0;
        hi = 0; t = 0; seen = 1'b0;
        while (!seen && t < 100) begin
            @(negedge clk);
            if (mem_req) hi++;
            if (if_valid) seen = 1'b1;
            t++;
        end
        chk("timeout_req_cycles", hi, TIMEOUT);
        chk("timeout_valid_seen", seen, 1'b1);
        chk("timeout_bus_err", bus_err, 1'b1);
        repeat (3) @(negedge clk);
        chk("timeout_bus_err_sticky", bus_err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("rst_clears_bus_err", bus_err, 1'b0);

        // Misaligned data load: proceeds on aligned word, flags error.
        mis = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h82, 32'h0, 0, 1'b1, 32'h0, 32'hCAFE_F00D};
        run_vec(mis, "misaligned");
        chk("misaligned_bus_err", bus_err, 1'b1);
        do_reset();

        // Reset in WAIT, then a late ack while idle.
        ack_delay = -1;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        t = 0;
        do begin @(negedge clk); t++; end while (!d_gnt && t < 20);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_busy_before_rst", busy, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; stray_ack = 1'b1;
        @(posedge clk); #1 stray_ack = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("rstwait_busy%0d", j), busy, 1'b0);
            chk($sformatf("rstwait_mem_req%0d", j), mem_req, 1'b0);
            chk($sformatf("rstwait_valids%0d", j), {if_valid, d_valid}, 2'b00);
            chk($sformatf("rstwait_bus_err%0d", j), bus_err, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
